rps_match_ctrl: RTL

Sequencing controller for a two-player rock-paper-scissors match. It collects one move per round from each player over independent valid/ready handshakes and judges each round with two instances of the existing `winnerA` comparator. It keeps the running score and declares the match winner once either player reaches a configurable win count. It sits between the player input front-ends and the score/display logic.

---
 rtl/rps_pkg.sv | 33 +++
 rtl/winnerA.sv | 24 ++
 rtl/rps_match_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/rps_pkg.sv
// Shared types for the rock-paper-scissors match controller: move/result
// encodings, FSM states and the legality helper used by the comparator.
package rps_pkg;

  localparam int unsigned MOVE_W   = 3;
  localparam int unsigned RESULT_W = 2;

  typedef enum logic [MOVE_W-1:0] {
    SCISSORS = 3'b001,
    ROCK     = 3'b010,
    PAPER    = 3'b100
  } move_e;

  typedef enum logic [RESULT_W-1:0] {
    RES_DRAW = 2'b00,
    RES_A    = 2'b01,
    RES_B    = 2'b10
  } result_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_JUDGE   = 3'd2,
    ST_REPORT  = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Exactly one bit set means a legal move.
  function automatic logic is_legal(input logic [MOVE_W-1:0] m);
    return $onehot(m);
  endfunction

endpackage

// File: rtl/winnerA.sv
// Round comparator: high when move a beats move b. An illegal move loses to
// any legal one; two illegal moves or two equal legal moves are no win.
module winnerA
  import rps_pkg::*;
(
  input  logic [MOVE_W-1:0] move_a_i,
  input  logic [MOVE_W-1:0] move_b_i,
  output logic              win_c
);

  logic a_ok;
  logic b_ok;
  logic beats;

  always_comb begin
    a_ok  = is_legal(move_a_i);
    b_ok  = is_legal(move_b_i);
    beats = ((move_a_i == ROCK)     && (move_b_i == SCISSORS)) ||
            ((move_a_i == SCISSORS) && (move_b_i == PAPER))    ||
            ((move_a_i == PAPER)    && (move_b_i == ROCK));
    win_c = a_ok && (!b_ok || beats);
  end

endmodule

// File: rtl/rps_match_ctrl.sv
// Two-player match sequencer: collects one move per player per round,
// judges it, keeps score and declares the match winner at WIN_TARGET wins.
module rps_match_ctrl
  import rps_pkg::*;
#(
  parameter int unsigned WIN_TARGET = 3,
  parameter int unsigned SCORE_W    = 4,
  parameter int unsigned ROUND_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [MOVE_W-1:0]   moveA,
  input  logic                validA,
  output logic                readyA,
  input  logic [MOVE_W-1:0]   moveB,
  input  logic                validB,
  output logic                readyB,
  output logic                busy,
  output logic                round_done,
  output logic [RESULT_W-1:0] round_result,
  output logic [SCORE_W-1:0]  scoreA,
  output logic [SCORE_W-1:0]  scoreB,
  output logic [ROUND_W-1:0]  round_num,
  output logic                match_done,
  output logic [RESULT_W-1:0] match_winner
);

  localparam logic [SCORE_W-1:0] TARGET = SCORE_W'(WIN_TARGET);

  state_e state_q, state_d;

  logic               lat_a_q, lat_a_d;
  logic               lat_b_q, lat_b_d;
  logic [MOVE_W-1:0]  mov_a_q, mov_a_d;
  logic [MOVE_W-1:0]  mov_b_q, mov_b_d;
  logic [SCORE_W-1:0] score_a_q, score_a_d;
  logic [SCORE_W-1:0] score_b_q, score_b_d;
  logic [ROUND_W-1:0] round_q, round_d;
  result_e            result_q, result_d;

  logic               ready_a_q, ready_a_d;
  logic               ready_b_q, ready_b_d;
  logic               busy_q, busy_d;
  logic               rdone_q, rdone_d;
  logic               mdone_q, mdone_d;
  result_e            winner_q, winner_d;

  logic win_a_c;
  logic win_b_c;
  logic acc_a;
  logic acc_b;

  winnerA u_win_a (
    .move_a_i (mov_a_q),
    .move_b_i (mov_b_q),
    .win_c    (win_a_c)
  );

  winnerA u_win_b (
    .move_a_i (mov_b_q),
    .move_b_i (mov_a_q),
    .win_c    (win_b_c)
  );

  // Next state, datapath next values and registered-output next values.
  always_comb begin
    state_d   = state_q;
    lat_a_d   = lat_a_q;
    lat_b_d   = lat_b_q;
    mov_a_d   = mov_a_q;
    mov_b_d   = mov_b_q;
    score_a_d = score_a_q;
    score_b_d = score_b_q;
    round_d   = round_q;
    result_d  = result_q;

    acc_a = (state_q == ST_COLLECT) && !lat_a_q && validA;
    acc_b = (state_q == ST_COLLECT) && !lat_b_q && validB;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_COLLECT;
          lat_a_d   = 1'b0;
          lat_b_d   = 1'b0;
          score_a_d = '0;
          score_b_d = '0;
          round_d   = '0;
          result_d  = RES_DRAW;
        end
      end
      ST_COLLECT: begin
        if (acc_a) begin
          lat_a_d = 1'b1;
          mov_a_d = moveA;
        end
        if (acc_b) begin
          lat_b_d = 1'b1;
          mov_b_d = moveB;
        end
        if (lat_a_d && lat_b_d) state_d = ST_JUDGE;
      end
      ST_JUDGE: begin
        if (win_a_c) begin
          result_d  = RES_A;
          score_a_d = score_a_q + SCORE_W'(1);
        end else if (win_b_c) begin
          result_d  = RES_B;
          score_b_d = score_b_q + SCORE_W'(1);
        end else begin
          result_d  = RES_DRAW;
        end
        if (round_q != '1) round_d = round_q + ROUND_W'(1);
        lat_a_d = 1'b0;
        lat_b_d = 1'b0;
        state_d = ST_REPORT;
      end
      ST_REPORT: begin
        if ((score_a_q == TARGET) || (score_b_q == TARGET)) state_d = ST_DONE;
        else                                                state_d = ST_COLLECT;
      end
      default: state_d = ST_IDLE;
    endcase

    ready_a_d = (state_d == ST_COLLECT) && !lat_a_d;
    ready_b_d = (state_d == ST_COLLECT) && !lat_b_d;
    busy_d    = (state_d != ST_IDLE) && (state_d != ST_DONE);
    rdone_d   = (state_d == ST_REPORT);
    mdone_d   = (state_d == ST_DONE);
    winner_d  = RES_DRAW;
    if (state_d == ST_DONE) winner_d = (score_a_d == TARGET) ? RES_A : RES_B;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Datapath and output registers; outputs are precomputed from next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_a_q   <= 1'b0;
      lat_b_q   <= 1'b0;
      mov_a_q   <= '0;
      mov_b_q   <= '0;
      score_a_q <= '0;
      score_b_q <= '0;
      round_q   <= '0;
      result_q  <= RES_DRAW;
      ready_a_q <= 1'b0;
      ready_b_q <= 1'b0;
      busy_q    <= 1'b0;
      rdone_q   <= 1'b0;
      mdone_q   <= 1'b0;
      winner_q  <= RES_DRAW;
    end else begin
      lat_a_q   <= lat_a_d;
      lat_b_q   <= lat_b_d;
      mov_a_q   <= mov_a_d;
      mov_b_q   <= mov_b_d;
      score_a_q <= score_a_d;
      score_b_q <= score_b_d;
      round_q   <= round_d;
      result_q  <= result_d;
      ready_a_q <= ready_a_d;
      ready_b_q <= ready_b_d;
      busy_q    <= busy_d;
      rdone_q   <= rdone_d;
      mdone_q   <= mdone_d;
      winner_q  <= winner_d;
    end
  end

  assign readyA       = ready_a_q;
  assign readyB       = ready_b_q;
  assign busy         = busy_q;
  assign round_done   = rdone_q;
  assign round_result = result_q;
  assign scoreA       = score_a_q;
  assign scoreB       = score_b_q;
  assign round_num    = round_q;
  assign match_done   = mdone_q;
  assign match_winner = winner_q;

endmodule
